// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
//
// This module is a multi-cycle data-memory controller that sits between the
// pipeline MEM stage and an off-chip 16-bit asynchronous SRAM. It splits each
// 32-bit load or store into two halfword accesses: the low half first, then the
// high half. Each access is held on the SRAM pins for WAIT_CYCLES clocks.
// While a transaction is in flight, ready stays low, and the top level uses
// ~ready to freeze the pipeline.
//
// Handshake: the MEM stage raises rdEn or wrEn and holds the request,
// address and data stable for as long as ready is 0. The request is
// accepted on the first edge seen in IDLE. The transaction completes in
// DONE, where ready is 1 for exactly one cycle and the pipeline advances
// on that edge. A request that is still visible in DONE is taken only
// after the controller returns to IDLE. When rdEn and wrEn are both high,
// the write wins.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   rdEn/wrEn  load / store request from MEM stage
//   address    byte address; BASE_ADDR maps to SRAM halfword 0
//   writeData  store data
//   readData   load data, registered, changed only by reads
//   ready      1 = idle with no request, or transaction complete
//   sramAddr   SRAM halfword address
//   sramDqOut  SRAM write data
//   sramDqIn   SRAM read data
//   sramDqOe   1 = controller drives the DQ bus
//   sramWeN    SRAM write enable, active-low
//   dbgState   current FSM state (0 IDLE, 1 ACC_LO, 2 ACC_HI, 3 DONE)
// -----------------------------------------------------------------------------
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 4,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdEn,
  input  logic               wrEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN,
  output logic [1:0]         dbgState
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACC_LO = 2'd1,
    S_ACC_HI = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_cnt;
  logic [3:0]         w_next_cnt;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_wdata;
  logic               r_is_wr;
  logic [31:0]        r_read_data;

  logic               w_req;
  logic               w_cnt_last;
  logic               w_accept;
  logic [31:0]        w_offset;
  logic               w_unused;

  assign w_req      = rdEn | wrEn;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_accept   = (r_state == S_IDLE) && w_req;

  // Only the halfword-pair index is kept. The subtraction wraps, and the
  // bits above the SRAM range are dropped without a range check.
  assign w_offset = address - BASE_ADDR;
  assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

  // State register and phase counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Transaction latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word  <= '0;
      r_wdata <= 32'd0;
      r_is_wr <= 1'b0;
    end else if (w_accept) begin
      r_word  <= w_offset[SRAM_AW:2];
      r_wdata <= writeData;
      r_is_wr <= wrEn;
    end
  end

  // Each read half is captured on the last cycle of its phase. This gives
  // the SRAM the whole wait window to settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data <= 32'd0;
    end else if (!r_is_wr && w_cnt_last) begin
      if (r_state == S_ACC_LO) r_read_data[15:0]  <= sramDqIn;
      if (r_state == S_ACC_HI) r_read_data[31:16] <= sramDqIn;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    ready        = 1'b0;
    sramAddr     = '0;
    sramDqOut    = 16'd0;
    sramDqOe     = 1'b0;
    sramWeN      = 1'b1;

    case (r_state)
      S_IDLE: begin
        ready = ~w_req;
        if (w_req) begin
          w_next_state = S_ACC_LO;
          w_next_cnt   = 4'd0;
        end
      end
      S_ACC_LO: begin
        sramAddr  = {r_word, 1'b0};
        sramDqOut = r_is_wr ? r_wdata[15:0] : 16'd0;
        sramDqOe  = r_is_wr;
        sramWeN   = ~r_is_wr;
        if (w_cnt_last) begin
          w_next_cnt   = 4'd0;
          w_next_state = S_ACC_HI;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end
      S_ACC_HI: begin
        sramAddr  = {r_word, 1'b1};
        sramDqOut = r_is_wr ? r_wdata[31:16] : 16'd0;
        sramDqOe  = r_is_wr;
        sramWeN   = ~r_is_wr;
        if (w_cnt_last) begin
          w_next_cnt   = 4'd0;
          w_next_state = S_DONE;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        ready        = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign readData = r_read_data;
  assign dbgState = r_state;

endmodule

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
//
// This bench drives two controllers from one clock and one reset:
//   u_dut4  uses WAIT_CYCLES=4 and carries the main transaction table
//   u_dut1  uses WAIT_CYCLES=1 and runs a back-to-back read sequence
// Each controller drives a small behavioural SRAM. The expected readData
// for every table transaction goes through exp_q.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

  logic clk;
  logic rst;

  // ---- dut4 signals
  logic        rd4, wr4;
  logic [31:0] addr4, wd4;
  logic [31:0] rdata4;
  logic        ready4;
  logic [17:0] saddr4;
  logic [15:0] dqout4, dqin4;
  logic        oe4, wen4;
  logic [1:0]  st4;

  // ---- dut1 signals
  logic        rd1, wr1;
  logic [31:0] addr1, wd1;
  logic [31:0] rdata1;
  logic        ready1;
  logic [17:0] saddr1;
  logic [15:0] dqout1, dqin1;
  logic        oe1, wen1;
  logic [1:0]  st1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  logic [15:0] mem4 [0:63];
  logic [15:0] mem1 [0:63];

  sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(4), .SRAM_AW(18)) u_dut4 (
    .clk(clk), .rst(rst), .rdEn(rd4), .wrEn(wr4), .address(addr4),
    .writeData(wd4), .readData(rdata4), .ready(ready4), .sramAddr(saddr4),
    .sramDqOut(dqout4), .sramDqIn(dqin4), .sramDqOe(oe4), .sramWeN(wen4),
    .dbgState(st4)
  );

  sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) u_dut1 (
    .clk(clk), .rst(rst), .rdEn(rd1), .wrEn(wr1), .address(addr1),
    .writeData(wd1), .readData(rdata1), .ready(ready1), .sramAddr(saddr1),
    .sramDqOut(dqout1), .sramDqIn(dqin1), .sramDqOe(oe1), .sramWeN(wen1),
    .dbgState(st1)
  );

  // ---- behavioural SRAMs (low 6 address bits decoded)
  assign dqin4 = mem4[saddr4[5:0]];
  assign dqin1 = mem1[saddr1[5:0]];

  always @(posedge clk) begin
    if (!wen4) mem4[saddr4[5:0]] <= dqout4;
    if (!wen1) mem1[saddr1[5:0]] <= dqout1;
  end

  // ---- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- comparison helper
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_idle_pins4(input string nm);
    check({nm, ".weN"}, {31'd0, wen4}, 32'd1);
    check({nm, ".oe"},  {31'd0, oe4},  32'd0);
    check({nm, ".addr"}, {14'd0, saddr4}, 32'd0);
    check({nm, ".dq"},  {16'd0, dqout4}, 32'd0);
  endtask

  // ---- transaction table record
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] hw_lo;
    logic [17:0] hw_hi;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // Run one table transaction on u_dut4 and check it cycle by cycle.
  // The bench starts and ends the transaction at a negedge.
  task automatic run_txn(input vec_t v, input int idx);
    string tag;
    logic [15:0] exp_dq;
    logic [31:0] exp_rd;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    rd4 = v.rd; wr4 = v.wr; addr4 = v.addr; wd4 = v.wdata;
    exp_q.push_back(v.exp_rdata);
    @(negedge clk);
    check({tag, ".req_ready"}, {31'd0, ready4}, 32'd0);
    check({tag, ".req_state"}, {30'd0, st4}, 32'd0);
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (v.wr) exp_dq = (ph == 0) ? v.wdata[15:0] : v.wdata[31:16];
        else      exp_dq = 16'd0;
        check($sformatf("%s.p%0d.c%0d.addr", tag, ph, c), {14'd0, saddr4},
              {14'd0, (ph == 0) ? v.hw_lo : v.hw_hi});
        check($sformatf("%s.p%0d.c%0d.weN", tag, ph, c), {31'd0, wen4}, {31'd0, ~v.wr});
        check($sformatf("%s.p%0d.c%0d.oe", tag, ph, c), {31'd0, oe4}, {31'd0, v.wr});
        check($sformatf("%s.p%0d.c%0d.dq", tag, ph, c), {16'd0, dqout4}, {16'd0, exp_dq});
        check($sformatf("%s.p%0d.c%0d.ready", tag, ph, c), {31'd0, ready4}, 32'd0);
        check($sformatf("%s.p%0d.c%0d.state", tag, ph, c), {30'd0, st4}, 32'(ph + 1));
      end
    end
    @(negedge clk);
    check({tag, ".done_ready"}, {31'd0, ready4}, 32'd1);
    check({tag, ".done_state"}, {30'd0, st4}, 32'd3);
    check_idle_pins4({tag, ".done"});
    exp_rd = exp_q.pop_front();
    check({tag, ".rdata"}, rdata4, exp_rd);
    @(posedge clk); #1;
    rd4 = 1'b0; wr4 = 1'b0;
    @(negedge clk);
    check({tag, ".idle_ready"}, {31'd0, ready4}, 32'd1);
    check({tag, ".idle_state"}, {30'd0, st4}, 32'd0);
  endtask

  logic [17:0] b2b_hw [4];
  logic [31:0] b2b_addr [2];
  logic [31:0] b2b_data [2];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem4[i] = 16'd0;
      mem1[i] = 16'd0;
    end
    mem1[0] = 16'hA001; mem1[1] = 16'hB002;
    mem1[4] = 16'hC003; mem1[5] = 16'hD004;

    //              rd    wr    addr        wdata          lo         hi         readData
    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2,     18'd3,     32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2,     18'd3,     32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0,     18'd1,     32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1036, 32'hA5A55A5A, 18'd6,     18'd7,     32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 18'd0,     18'd1,     32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'd1039, 32'h00000000, 18'd6,     18'd7,     32'hA5A55A5A};
    vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 18'h3FFFF, 32'hA5A55A5A};
    vecs[7] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 18'h3FFFE, 18'h3FFFF, 32'hCAFEF00D};

    // ---- reset with a pending read request
    rst = 1'b0;
    rd4 = 1'b1; wr4 = 1'b0; addr4 = 32'd1028; wd4 = 32'd0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0;    wd1 = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d.rdata", i), rdata4, 32'd0);
      check_idle_pins4($sformatf("rst%0d", i));
      check($sformatf("rst%0d.state", i), {30'd0, st4}, 32'd0);
      check($sformatf("rst%0d.ready", i), {31'd0, ready4}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rel.state_still_idle", {30'd0, st4}, 32'd0);
    @(negedge clk);
    check("rel.accept_state", {30'd0, st4}, 32'd1);
    check("rel.accept_addr", {14'd0, saddr4}, 32'd2);
    // Abort this read asynchronously in the middle of a cycle
    rst = 1'b0;
    #1;
    check("abort.state", {30'd0, st4}, 32'd0);
    check_idle_pins4("abort");
    rd4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort.ready", {31'd0, ready4}, 32'd1);
    check("abort.rdata", rdata4, 32'd0);

    // ---- table-driven transactions
    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // ---- reset during the second cycle of ACC_HI of a write
    @(posedge clk); #1;
    wr4 = 1'b1; addr4 = 32'd1028; wd4 = 32'h11112222;
    repeat (6) @(negedge clk);   // request cycle, 4x ACC_LO, ACC_HI cycle 1
    check("mid.pre_state", {30'd0, st4}, 32'd2);
    @(posedge clk); #2;
    check("mid.c2_weN", {31'd0, wen4}, 32'd0);
    rst = 1'b0;
    #1;
    check_idle_pins4("mid");
    check("mid.state", {30'd0, st4}, 32'd0);
    check("mid.ready_req", {31'd0, ready4}, 32'd0);
    check("mid.rdata", rdata4, 32'd0);
    wr4 = 1'b0;
    #1;
    check("mid.ready_noreq", {31'd0, ready4}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid.quiet%0d.weN", i), {31'd0, wen4}, 32'd1);
      check($sformatf("mid.quiet%0d.state", i), {30'd0, st4}, 32'd0);
    end

    // ---- WAIT_CYCLES=1: back-to-back reads with rdEn held high
    b2b_addr[0] = 32'd1024; b2b_addr[1] = 32'd1032;
    b2b_data[0] = 32'hB002A001; b2b_data[1] = 32'hD004C003;
    b2b_hw[0] = 18'd0; b2b_hw[1] = 18'd1; b2b_hw[2] = 18'd4; b2b_hw[3] = 18'd5;
    @(posedge clk); #1;
    rd1 = 1'b1; addr1 = b2b_addr[0];
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      check($sformatf("b2b%0d.req_ready", t), {31'd0, ready1}, 32'd0);
      check($sformatf("b2b%0d.req_state", t), {30'd0, st1}, 32'd0);
      for (int ph = 0; ph < 2; ph++) begin
        @(negedge clk);
        check($sformatf("b2b%0d.p%0d.addr", t, ph), {14'd0, saddr1}, {14'd0, b2b_hw[2*t+ph]});
        check($sformatf("b2b%0d.p%0d.weN", t, ph), {31'd0, wen1}, 32'd1);
        check($sformatf("b2b%0d.p%0d.ready", t, ph), {31'd0, ready1}, 32'd0);
      end
      @(negedge clk);
      check($sformatf("b2b%0d.done_ready", t), {31'd0, ready1}, 32'd1);
      check($sformatf("b2b%0d.done_state", t), {30'd0, st1}, 32'd3);
      check($sformatf("b2b%0d.rdata", t), rdata1, b2b_data[t]);
      @(posedge clk); #1;
      if (t == 0) addr1 = b2b_addr[1];
      else rd1 = 1'b0;
    end
    @(negedge clk);
    check("b2b.final_ready", {31'd0, ready1}, 32'd1);
    check("b2b.final_state", {30'd0, st1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
